// File: rtl/uma_pkg.sv
// Shared types and helpers for the UMA slot arbiter: FSM states, arbitration
// modes and the round-robin pick function.
package uma_pkg;

  localparam int MAX_COUNT = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_t;

  typedef enum logic {
    MODE_TDM = 1'b0,
    MODE_RR  = 1'b1
  } arb_mode_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Lowest asserted index at or above ptr, wrapping. Unused upper request bits
  // must be zero, so wrapping modulo MAX_COUNT matches wrapping modulo COUNT.
  function automatic rr_pick_t rr_pick(input logic [MAX_COUNT-1:0] req,
                                       input logic [IDX_W-1:0]     ptr);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int i = 0; i < MAX_COUNT; i++) begin
      cand = ptr + IDX_W'(i);
      if (!pick.valid && req[cand]) begin
        pick.valid = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uma_slot_arbiter_if.sv
// Requester, bus-timing and primary RAM port bundle of the UMA slot arbiter.
// The arbiter takes the slave view; requesters and the SDRAM side take master.
interface uma_slot_arbiter_if #(
  parameter int COUNT = 2,
  parameter int AW    = 23,
  parameter int DW    = 16
);

  logic                clk_en;
  logic [COUNT*AW-1:0] base;
  logic [COUNT-1:0]    req;
  logic [COUNT-1:0]    we;
  logic [COUNT*AW-1:0] addr;
  logic [COUNT*DW-1:0] wdata;
  logic [COUNT-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic [COUNT-1:0]    timing;
  logic [COUNT-1:0]    err;
  logic                p_req;
  logic                p_we;
  logic [AW-1:0]       p_addr;
  logic [DW-1:0]       p_wdata;
  logic                p_ack;
  logic [DW-1:0]       p_rdata;

  modport slave (
    input  clk_en, base, req, we, addr, wdata, p_ack, p_rdata,
    output ack, rdata, timing, err, p_req, p_we, p_addr, p_wdata
  );

  modport master (
    output clk_en, base, req, we, addr, wdata, p_ack, p_rdata,
    input  ack, rdata, timing, err, p_req, p_we, p_addr, p_wdata
  );

endinterface

// File: rtl/uma_slot_timer.sv
// Slot counter locked to the bus clock enable; decodes the start of each
// channel's window into a registered one-cycle TIMING pulse.
module uma_slot_timer #(
  parameter int COUNT = 2,
  parameter int DIV   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en_i,
  output logic [COUNT-1:0] timing_o
);

  localparam int CW = $clog2(DIV);
  localparam int W  = DIV / COUNT;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [COUNT-1:0] timing_q, timing_d;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clk_en_i || cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
    end
    timing_d = '0;
    for (int k = 0; k < COUNT; k++) begin
      timing_d[k] = (cnt_d == CW'(k * W));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      timing_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      timing_q <= timing_d;
    end
  end

  assign timing_o = timing_q;

endmodule

// File: rtl/uma_slot_arbiter.sv
// Arbitrates COUNT requesters onto one SDRAM-side port, by TDM slots or
// round-robin, with per-channel base relocation and a primary-side timeout.
module uma_slot_arbiter
  import uma_pkg::*;
#(
  parameter int        COUNT   = 2,
  parameter int        AW      = 23,
  parameter int        DW      = 16,
  parameter int        DIV     = 30,
  parameter arb_mode_t MODE    = MODE_TDM,
  parameter int        TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  uma_slot_arbiter_if.slave bus
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int TW = $clog2(TIMEOUT);

  if (COUNT < 1 || COUNT > MAX_COUNT || DIV < 2 * COUNT || TIMEOUT < 4) begin : g_bad_params
    $fatal(1, "uma_slot_arbiter: need 1 <= COUNT <= 8, DIV >= 2*COUNT, TIMEOUT >= 4");
  end

  logic [COUNT-1:0] timing;

  uma_slot_timer #(
    .COUNT (COUNT),
    .DIV   (DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (bus.clk_en),
    .timing_o (timing)
  );

  arb_state_t       state_q;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    tmo_q;
  logic             p_req_q, p_we_q;
  logic [AW-1:0]    p_addr_q;
  logic [DW-1:0]    p_wdata_q, rdata_q;
  logic [COUNT-1:0] ack_q, err_q;

  rr_pick_t         pick;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pick    = rr_pick(MAX_COUNT'(bus.req), IDX_W'(ptr_q));
    if (MODE == MODE_RR) begin
      gnt_vld = pick.valid;
      for (int k = 0; k < COUNT; k++) begin
        if (pick.idx == IDX_W'(k)) gnt_idx = IW'(k);
      end
    end else begin
      // Only one TIMING bit is ever high, so at most one channel matches.
      for (int k = 0; k < COUNT; k++) begin
        if (timing[k] && bus.req[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = IW'(k);
        end
      end
    end
    ptr_d     = (gnt_idx == IW'(COUNT - 1)) ? '0 : gnt_idx + IW'(1);
    sel_addr  = bus.base[int'(gnt_idx)*AW +: AW] + bus.addr[int'(gnt_idx)*AW +: AW];
    sel_wdata = bus.wdata[int'(gnt_idx)*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      tmo_q     <= '0;
      p_req_q   <= 1'b0;
      p_we_q    <= 1'b0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            state_q   <= ISSUE;
            grant_q   <= gnt_idx;
            tmo_q     <= '0;
            p_req_q   <= 1'b1;
            p_we_q    <= bus.we[gnt_idx];
            p_addr_q  <= sel_addr;
            p_wdata_q <= sel_wdata;
            if (MODE == MODE_RR) ptr_q <= ptr_d;
          end
        end
        ISSUE: begin
          // P_ACK is tested first so it wins over a same-cycle timeout.
          if (bus.p_ack) begin
            state_q <= DONE;
            p_req_q <= 1'b0;
            rdata_q <= bus.p_rdata;
            ack_q   <= COUNT'(1) << grant_q;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= DONE;
            p_req_q <= 1'b0;
            err_q   <= COUNT'(1) << grant_q;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.timing  = timing;
  assign bus.p_req   = p_req_q;
  assign bus.p_we    = p_we_q;
  assign bus.p_addr  = p_addr_q;
  assign bus.p_wdata = p_wdata_q;
  assign bus.rdata   = rdata_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_uma_slot_arbiter.sv
// Bench for uma_slot_arbiter: a 2-channel TDM instance and a 4-channel
// round-robin instance share clock, reset and CLK_EN; completions are scoreboarded.
module tb_uma_slot_arbiter;
  import uma_pkg::*;

  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int DIV = 30;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uma_slot_arbiter_if #(.COUNT(2), .AW(AW), .DW(DW)) bus0 ();
  uma_slot_arbiter_if #(.COUNT(4), .AW(AW), .DW(DW)) bus1 ();

  uma_slot_arbiter #(.COUNT(2), .AW(AW), .DW(DW), .DIV(DIV), .MODE(MODE_TDM), .TIMEOUT(TMO))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uma_slot_arbiter #(.COUNT(4), .AW(AW), .DW(DW), .DIV(DIV), .MODE(MODE_RR), .TIMEOUT(TMO))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total  = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    logic          is_err;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC35A ^ {9'b0, a[22:16]};
  endfunction

  // Reference bus-slot count and "first cycle after reset" flag.
  int m_cnt;
  bit m_fresh;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_fresh <= 1'b1;
    end else begin
      m_fresh <= 1'b0;
      m_cnt   <= (bus0.clk_en || m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    end
  end

  function automatic logic [1:0] exp_tim0();
    return m_fresh ? 2'b00 : {m_cnt == 15, m_cnt == 0};
  endfunction
  function automatic logic [3:0] exp_tim1();
    return m_fresh ? 4'b0000 : {m_cnt == 21, m_cnt == 14, m_cnt == 7, m_cnt == 0};
  endfunction

  // Bus clock enable: periodic at count DIV-1, or forced for one cycle.
  bit en_auto = 1'b0;
  bit force_en = 1'b0;
  initial begin
    bus0.clk_en = 1'b0;
    bus1.clk_en = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus0.clk_en = force_en || (en_auto && m_cnt == DIV - 1);
      bus1.clk_en = bus0.clk_en;
    end
  end

  // Primary RAM models: P_ACK lat cycles after P_REQ is first seen.
  bit            resp_en0 = 1'b1, resp_en1 = 1'b1;
  int            lat0 = 4, lat1 = 2;
  logic [AW-1:0] a0, a1;
  initial begin
    bus0.p_ack = 1'b0;
    bus0.p_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en0 && bus0.p_req) begin
        a0 = bus0.p_addr;
        repeat (lat0) @(negedge clk);
        bus0.p_ack = 1'b1;
        bus0.p_rdata = rd_fn(a0);
        @(negedge clk);
        bus0.p_ack = 1'b0;
        bus0.p_rdata = '0;
        while (bus0.p_req) @(negedge clk);
      end
    end
  end
  initial begin
    bus1.p_ack = 1'b0;
    bus1.p_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en1 && bus1.p_req) begin
        a1 = bus1.p_addr;
        repeat (lat1) @(negedge clk);
        bus1.p_ack = 1'b1;
        bus1.p_rdata = rd_fn(a1);
        @(negedge clk);
        bus1.p_ack = 1'b0;
        bus1.p_rdata = '0;
        while (bus1.p_req) @(negedge clk);
      end
    end
  end

  // Scoreboard monitors: every ACK/ERR pulse must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (bus0.ack != 0 || bus0.err != 0)) begin
      if (sb0.size() == 0) check("sb0_unexpected", {30'b0, bus0.err}, 0);
      else begin
        e0 = sb0.pop_front();
        check("sb0_ack", {30'b0, bus0.ack}, e0.is_err ? 0 : (1 << e0.ch));
        check("sb0_err", {30'b0, bus0.err}, e0.is_err ? (1 << e0.ch) : 0);
        if (!e0.is_err) check("sb0_rdata", {16'b0, bus0.rdata}, {16'b0, e0.data});
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && (bus1.ack != 0 || bus1.err != 0)) begin
      if (sb1.size() == 0) check("sb1_unexpected", {28'b0, bus1.ack}, 0);
      else begin
        e1 = sb1.pop_front();
        check("sb1_ack", {28'b0, bus1.ack}, 1 << e1.ch);
        check("sb1_err", {28'b0, bus1.err}, 0);
        check("sb1_rdata", {16'b0, bus1.rdata}, {16'b0, e1.data});
      end
    end
  end

  task automatic tim_check(input int cycles, input bit both);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("timing0", {30'b0, bus0.timing}, {30'b0, exp_tim0()});
      if (both) check("timing1", {28'b0, bus1.timing}, {28'b0, exp_tim1()});
    end
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != c && n < 64);
    check("wait_cnt", m_cnt, c);
  endtask

  task automatic wait_preq0(input int exp_cnt, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.p_req && n < 40);
    check({tag, "_preq"}, {31'b0, bus0.p_req}, 1);
    check({tag, "_grant_cnt"}, m_cnt, exp_cnt);
  endtask

  task automatic wait_ack0(input int exp_cnt, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.ack == 0 && n < 20);
    check({tag, "_ack_cnt"}, m_cnt, exp_cnt);
    bus0.req = '0;
    bus0.we  = '0;
  endtask

  task automatic run_rr(input int n_acks);
    int got = 0;
    int n   = 0;
    while (got < n_acks && n < 100) begin
      @(negedge clk);
      n++;
      if (bus1.ack != 0) got++;
    end
    bus1.req = '0;
    check("rr_ack_count", got, n_acks);
  endtask

  int hi;

  initial begin
    rst = 1'b1;
    bus0.base  = {23'h400000, 23'h000100};
    bus0.addr  = {23'h000010, 23'h000000};
    bus0.req   = '0;
    bus0.we    = '0;
    bus0.wdata = '0;
    bus1.base  = {23'h030000, 23'h020000, 23'h010000, 23'h000000};
    bus1.addr  = {23'd3, 23'd2, 23'd1, 23'd0};
    bus1.req   = '0;
    bus1.we    = '0;
    bus1.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_p_req0", {31'b0, bus0.p_req}, 0);
    check("rst_p_we0", {31'b0, bus0.p_we}, 0);
    check("rst_p_addr0", {9'b0, bus0.p_addr}, 0);
    check("rst_p_wdata0", {16'b0, bus0.p_wdata}, 0);
    check("rst_ack0", {30'b0, bus0.ack}, 0);
    check("rst_err0", {30'b0, bus0.err}, 0);
    check("rst_rdata0", {16'b0, bus0.rdata}, 0);
    check("rst_timing0", {30'b0, bus0.timing}, 0);
    check("rst_p_req1", {31'b0, bus1.p_req}, 0);
    check("rst_timing1", {28'b0, bus1.timing}, 0);
    rst = 1'b0;
    en_auto = 1'b1;

    // TIMING windows in both modes, then a mid-period CLK_EN resync
    tim_check(70, 1'b1);
    wait_cnt(10);
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    check("resync_cnt", m_cnt, 0);
    tim_check(40, 1'b1);

    // TDM read on channel 1 raised at count 3: granted only at count 15
    wait_cnt(3);
    bus0.req = 2'b10;
    sb0.push_back('{1, rd_fn(23'h400010), 1'b0});
    wait_preq0(16, "tdm_rd");
    check("tdm_rd_p_addr", {9'b0, bus0.p_addr}, 32'h400010);
    check("tdm_rd_p_we", {31'b0, bus0.p_we}, 0);
    wait_ack0(21, "tdm_rd");

    // TDM write on channel 0
    wait_cnt(25);
    bus0.req = 2'b01;
    bus0.we = 2'b01;
    bus0.wdata = {16'h1234, 16'hBEEF};
    sb0.push_back('{0, rd_fn(23'h000100), 1'b0});
    wait_preq0(1, "tdm_wr");
    check("tdm_wr_p_we", {31'b0, bus0.p_we}, 1);
    check("tdm_wr_p_wdata", {16'b0, bus0.p_wdata}, 32'hBEEF);
    check("tdm_wr_p_addr", {9'b0, bus0.p_addr}, 32'h000100);
    wait_ack0(6, "tdm_wr");

    // Round-robin, all channels requesting
    sb1.push_back('{0, rd_fn(23'h000000), 1'b0});
    sb1.push_back('{1, rd_fn(23'h010001), 1'b0});
    sb1.push_back('{2, rd_fn(23'h020002), 1'b0});
    sb1.push_back('{3, rd_fn(23'h030003), 1'b0});
    sb1.push_back('{0, rd_fn(23'h000000), 1'b0});
    bus1.req = 4'hF;
    run_rr(5);

    // Timeout: no P_ACK, P_REQ held exactly TMO cycles, then ERR only
    wait_cnt(25);
    resp_en0 = 1'b0;
    bus0.req = 2'b01;
    sb0.push_back('{0, '0, 1'b1});
    wait_preq0(1, "tmo");
    hi = 0;
    while (bus0.p_req && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_p_req_cycles", hi, TMO);
    check("tmo_err_pulse", {30'b0, bus0.err}, 32'h1);
    check("tmo_no_ack", {30'b0, bus0.ack}, 0);
    bus0.req = '0;
    resp_en0 = 1'b1;

    // Next request served normally, with base+addr wrapping mod 2^AW
    bus0.base[AW-1:0] = 23'h7FFFFF;
    bus0.addr[AW-1:0] = 23'h000002;
    wait_cnt(25);
    bus0.req = 2'b01;
    sb0.push_back('{0, rd_fn(23'h000001), 1'b0});
    wait_preq0(1, "wrap");
    check("wrap_p_addr", {9'b0, bus0.p_addr}, 32'h000001);
    wait_ack0(6, "wrap");

    // Reset during ISSUE; the late P_ACK must be ignored
    wait_cnt(3);
    bus0.req = 2'b10;
    wait_preq0(16, "rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus0.req = '0;
    #1;
    check("rst_mid_p_req", {31'b0, bus0.p_req}, 0);
    check("rst_mid_ack", {30'b0, bus0.ack}, 0);
    check("rst_mid_err", {30'b0, bus0.err}, 0);
    check("rst_mid_rdata", {16'b0, bus0.rdata}, 0);
    check("rst_mid_p_addr", {9'b0, bus0.p_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_ack0", {30'b0, bus0.ack}, 0);
      check("post_rst_err0", {30'b0, bus0.err}, 0);
      check("post_rst_p_req0", {31'b0, bus0.p_req}, 0);
      check("post_rst_timing0", {30'b0, bus0.timing}, {30'b0, exp_tim0()});
    end

    // Pointer back at 0: channels 0 then 1 with REQ=0011
    sb1.push_back('{0, rd_fn(23'h000000), 1'b0});
    sb1.push_back('{1, rd_fn(23'h010001), 1'b0});
    bus1.req = 4'b0011;
    run_rr(2);

    repeat (10) @(negedge clk);
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uma_slot_arbiter.md
Name: uma_slot_arbiter

Overview:
- Parametrised successor to the current two-port UMA sharing: arbitrates COUNT requesters onto one primary RAM port, which is the SDRAM controller side.
- Two arbitration modes:
  - time-division slots locked to the MSX bus clock enable;
  - work-conserving round-robin.
- Relocates each requester address by a per-channel base.
- Adds a primary-side timeout with error reporting.
- Sits between the SDRAM controller and MAIN/VDP RAM users.

Parameters:
- COUNT, 2, number of requester channels (2..8).
- AW, 23, address width in 16-bit words.
- DW, 16, data width.
- DIV, 30, CLK cycles per CLK_EN period (108 MHz / 3.58 MHz); must be >= 2*COUNT.
- MODE, 0, 0 = TDM slots, 1 = round-robin.
- TIMEOUT, 64, CLK cycles to wait for P_ACK before aborting (>= 4).

Ports:
- CLK  in  1  system clock (108 MHz).
- RESET  in  1  asynchronous, active-high reset.
- CLK_EN  in  1  one-cycle bus clock enable pulse.
- BASE  in  COUNT*AW  per-channel base address, channel k at [k*AW +: AW], quasi-static.
- REQ  in  COUNT  request level per channel.
- WE  in  COUNT  1 = write.
- ADDR  in  COUNT*AW  per-channel word address.
- WDATA  in  COUNT*DW  per-channel write data.
- ACK  out  COUNT  one-cycle completion pulse per channel.
- RDATA  out  DW  read data, valid in the ACK cycle, shared by all channels.
- TIMING  out  COUNT  one-cycle pulse at the start of each channel's slot window.
- ERR  out  COUNT  one-cycle pulse when that channel's transaction timed out.
- P_REQ  out  1  primary request level.
- P_WE  out  1  primary write enable.
- P_ADDR  out  AW  primary address.
- P_WDATA  out  DW  primary write data.
- P_ACK  in  1  primary completion pulse.
- P_RDATA  in  DW  primary read data, valid with P_ACK.

Behaviour:
- Reset values: every output 0; slot counter 0; round-robin pointer 0; state IDLE.
- Reset mid-transaction drops P_REQ immediately. No ACK or ERR is issued. A P_ACK that arrives after reset is ignored.
- Slot counter:
  - increments each CLK and wraps DIV-1 -> 0;
  - the cycle after CLK_EN, the counter is forced to 0, which resyncs it to the bus.
- Window width is W = DIV/COUNT (integer division). Channel k owns counts k*W .. k*W+W-1; any remainder counts belong to no channel.
- TIMING[k] pulses when the counter equals k*W. This happens in both modes.
- Requester protocol:
  - hold REQ, WE, ADDR and WDATA stable until the ACK pulse;
  - REQ may drop in the ACK cycle.
  - If REQ is withdrawn before ACK, the transaction still completes and ACK or ERR still pulses.
- States: IDLE, ISSUE, DONE.
- IDLE -> ISSUE (grant):
  - MODE 0: grant channel k only in the cycle TIMING[k] is high and REQ[k]=1. Otherwise the window stays idle.
  - MODE 1: grant the lowest index >= pointer, wrapping, among asserted REQ. The pointer then becomes the granted index + 1 mod COUNT.
  - Registered grant. In the cycle after the grant decision, P_REQ=1, P_ADDR = BASE[k] + ADDR[k] mod 2^AW, and P_WE/P_WDATA are taken from channel k.
- ISSUE: hold the P_* signals stable and count cycles.
  - P_ACK -> DONE, latching P_RDATA.
  - Counter reaching TIMEOUT without P_ACK -> DONE with the error flag set.
- DONE (1 cycle): P_REQ=0; pulse ACK[k] with RDATA valid, or ERR[k] (not ACK) on timeout; -> IDLE.
- Latency: minimum request-to-ACK is 3 CLK plus the primary latency.
- Only one primary transaction is in flight at a time.
- MODE 0: a transaction that overruns its window delays the next window's grant. That grant is lost for the period; it is not queued.
- Simultaneous P_ACK and timeout expiry in the same cycle: P_ACK wins.
- Elaboration-time assertion: DIV >= 2*COUNT and COUNT >= 1.

Decomposition:
- Shared package uma_pkg:
  - arb_state_t enum (IDLE, ISSUE, DONE);
  - arb_mode_t (MODE_TDM=0, MODE_RR=1);
  - function rr_pick(req, ptr) returning the granted index and a valid flag.
- One sub-module, uma_slot_timer: slot counter, CLK_EN resync, TIMING decode.
- The grant logic and state machine stay in uma_slot_arbiter.

Test Plan:
- Reset release, MODE=0, COUNT=2, DIV=30, CLK_EN every 30 cycles -> TIMING[0] at counts 0, TIMING[1] at counts 15; each exactly 1 cycle per period.
- MODE=0, REQ[1]=1 with ADDR=0x10 and BASE[1]=0x400000, raised at count 3 -> no grant until count 15. P_ADDR=0x400010. P_ACK returned 4 cycles later -> ACK[1] a further 1 cycle later, RDATA = P_RDATA.
- MODE=1, COUNT=4, REQ=4'b1111 held, P_ACK 2 cycles after each P_REQ -> grants in order 0,1,2,3,0; no channel is granted twice before the others.
- TIMEOUT=8, P_ACK never asserted -> P_REQ drops after 8 ISSUE cycles; ERR[k] pulses once; ACK[k] stays 0; the next request is served normally.
- Address wrap: BASE=0x7FFFFF, ADDR=0x2, AW=23 -> P_ADDR=0x000001.
- RESET asserted during ISSUE, then P_ACK arrives 2 cycles later -> all outputs 0, no ACK or ERR, pointer and counter 0, P_ACK ignored.
